// File: rtl/attr_pkg.sv
// Shared definitions for the attractor detector: default sizing, FSM
// state encoding and the period-field width helper.
package attr_pkg;

   localparam int DEF_N         = 8;
   localparam int DEF_DEPTH     = 16;
   localparam int DEF_MAX_STEPS = 1000;
   localparam int DEF_CNT_W     = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TRACK,
      ST_FOUND,
      ST_TMO
   } state_t;

   // Width needed to hold any period from 0 (none) up to depth.
   function automatic int calc_pw(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/attr_hist.sv
// Shift-register history of recent trajectory states. Entry 0 is the most
// recent state; match[k] flags a valid entry k equal to the incoming x.
module attr_hist
   import attr_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [N-1:0]     init,
   input  logic             push,
   input  logic [N-1:0]     x,
   output logic [DEPTH-1:0] match
);

   logic [N-1:0]     entry [DEPTH];
   logic [DEPTH-1:0] valid;

   // A load restarts the history with init as the only valid entry; a push
   // shifts everything one place older and lets the oldest fall off.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            entry[k] <= '0;
         end
         valid <= '0;
      end else if (load) begin
         for (int k = 0; k < DEPTH; k++) begin
            entry[k] <= (k == 0) ? init : '0;
         end
         valid <= DEPTH'(1);
      end else if (push) begin
         entry[0] <= x;
         for (int k = 1; k < DEPTH; k++) begin
            entry[k] <= entry[k-1];
         end
         valid <= (valid << 1) | DEPTH'(1);
      end
   end

   always_comb begin
      match = '0;
      for (int k = 0; k < DEPTH; k++) begin
         match[k] = valid[k] && (entry[k] == x);
      end
   end

endmodule

// File: rtl/attractor_detect.sv
// Watches a Boolean-network trajectory and reports the first repeated state,
// classifying it as a fixed point or a cycle, or times out after MAX_STEPS.
module attractor_detect
   import attr_pkg::*;
#(
   parameter int N         = DEF_N,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int MAX_STEPS = DEF_MAX_STEPS,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [N-1:0]                init,
   input  logic                        x_valid,
   input  logic [N-1:0]                x,
   output logic                        busy,
   output logic                        done,
   output logic                        fixed_pt,
   output logic                        cycle,
   output logic                        timeout,
   output logic [calc_pw(DEPTH)-1:0]   period,
   output logic [N-1:0]                entry_state,
   output logic [CNT_W-1:0]            steps
);

   localparam int PW = calc_pw(DEPTH);
   localparam logic [CNT_W-1:0] STEP_LIMIT = CNT_W'(MAX_STEPS);

   state_t           state;
   logic [DEPTH-1:0] match;
   logic             hit;
   logic             accept;
   logic [PW-1:0]    match_period;
   logic [CNT_W-1:0] steps_next;

   // start overrides any x presented in the same cycle.
   assign accept = (state == ST_TRACK) && x_valid && !start;
   assign hit    = |match;

   attr_hist #(
      .N     (N),
      .DEPTH (DEPTH)
   ) u_hist (
      .clk   (clk),
      .rst   (rst),
      .load  (start),
      .init  (init),
      .push  (accept),
      .x     (x),
      .match (match)
   );

   // The youngest matching entry gives the shortest period.
   always_comb begin
      match_period = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (match[k]) begin
            match_period = PW'(k + 1);
         end
      end
   end

   assign steps_next = (steps == '1) ? steps : steps + 1'b1;

   // A match on the last budgeted step still counts as a detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         fixed_pt    <= 1'b0;
         cycle       <= 1'b0;
         timeout     <= 1'b0;
         period      <= '0;
         entry_state <= '0;
         steps       <= '0;
      end else if (start) begin
         state       <= ST_TRACK;
         busy        <= 1'b1;
         done        <= 1'b0;
         fixed_pt    <= 1'b0;
         cycle       <= 1'b0;
         timeout     <= 1'b0;
         period      <= '0;
         entry_state <= '0;
         steps       <= '0;
      end else if (accept) begin
         steps <= steps_next;
         if (hit) begin
            state       <= ST_FOUND;
            busy        <= 1'b0;
            done        <= 1'b1;
            period      <= match_period;
            entry_state <= x;
            fixed_pt    <= (match_period == PW'(1));
            cycle       <= (match_period > PW'(1));
         end else if (steps_next >= STEP_LIMIT) begin
            state   <= ST_TMO;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            period  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_attractor_detect.sv
// Bench for attractor_detect: directed table, corner-case sequences and
// randomized trajectories compared against a trajectory-queue model.
module tb_attractor_detect;

   localparam int N         = 8;
   localparam int DEPTH     = 4;
   localparam int MAX_STEPS = 20;
   localparam int CNT_W     = 16;
   localparam int PW        = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [N-1:0]     init = '0;
   logic             x_valid = 1'b0;
   logic [N-1:0]     x = '0;
   logic             busy, done, fixed_pt, cycle, timeout;
   logic [PW-1:0]    period;
   logic [N-1:0]     entry_state;
   logic [CNT_W-1:0] steps;

   int n_checks = 0;
   int n_fail   = 0;

   attractor_detect #(
      .N         (N),
      .DEPTH     (DEPTH),
      .MAX_STEPS (MAX_STEPS),
      .CNT_W     (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .init        (init),
      .x_valid     (x_valid),
      .x           (x),
      .busy        (busy),
      .done        (done),
      .fixed_pt    (fixed_pt),
      .cycle       (cycle),
      .timeout     (timeout),
      .period      (period),
      .entry_state (entry_state),
      .steps       (steps)
   );

   always #5 clk = ~clk;

   // Reference model: keeps the whole trajectory since start and looks back
   // at most DEPTH states for the most recent earlier copy of x.
   logic [N-1:0] traj [$];
   logic         m_track, m_done, m_fixed, m_cycle, m_tmo;
   int           m_period, m_steps;
   logic [N-1:0] m_entry;

   function automatic void model_reset();
      traj.delete();
      m_track = 0; m_done = 0; m_fixed = 0; m_cycle = 0; m_tmo = 0;
      m_period = 0; m_steps = 0; m_entry = '0;
   endfunction

   function automatic void model_tick(input logic s, input logic [N-1:0] i,
                                      input logic xv, input logic [N-1:0] xx);
      int per;
      if (s) begin
         model_reset();
         traj.push_back(i);
         m_track = 1;
      end else if (m_track && xv) begin
         m_steps++;
         per = 0;
         for (int k = 0; k < DEPTH && k < traj.size(); k++) begin
            if (per == 0 && traj[traj.size() - 1 - k] == xx) per = k + 1;
         end
         traj.push_back(xx);
         if (per != 0) begin
            m_track = 0; m_done = 1; m_period = per; m_entry = xx;
            m_fixed = (per == 1); m_cycle = (per >= 2);
         end else if (m_steps == MAX_STEPS) begin
            m_track = 0; m_done = 1; m_tmo = 1; m_period = 0;
         end
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input string tag);
      chk({tag, ".busy"},     32'(busy),        32'(m_track));
      chk({tag, ".done"},     32'(done),        32'(m_done));
      chk({tag, ".fixed_pt"}, 32'(fixed_pt),    32'(m_fixed));
      chk({tag, ".cycle"},    32'(cycle),       32'(m_cycle));
      chk({tag, ".timeout"},  32'(timeout),     32'(m_tmo));
      chk({tag, ".period"},   32'(period),      32'(m_period));
      chk({tag, ".entry"},    32'(entry_state), 32'(m_entry));
      chk({tag, ".steps"},    32'(steps),       32'(m_steps));
   endtask

   task automatic applyStimulus(input logic s, input logic [N-1:0] i,
                                input logic xv, input logic [N-1:0] xx, input string tag);
      start = s; init = i; x_valid = xv; x = xx;
      @(posedge clk);
      model_tick(s, i, xv, xx);
      #1;
      start = 1'b0; x_valid = 1'b0;
      checkOutput(tag);
   endtask

   task automatic pulse_reset(input string tag);
      rst = 1'b1;
      #2;
      model_reset();
      checkOutput({tag, ".async"});
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   typedef struct {
      logic [N-1:0] init;
      int           nx;
      logic [N-1:0] xs [6];
      logic         exp_fixed;
      logic         exp_cycle;
      int           exp_period;
      logic [N-1:0] exp_entry;
      int           exp_steps;
   } vec_t;

   vec_t vecs [5];

   initial begin
      vecs[0] = '{8'h05, 1, '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 1, 8'h05, 1};
      vecs[1] = '{8'h01, 2, '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 2, 8'h01, 2};
      vecs[2] = '{8'hA0, 4, '{8'h11, 8'h22, 8'h33, 8'h22, 8'h00, 8'h00}, 1'b0, 1'b1, 2, 8'h22, 4};
      vecs[3] = '{8'h10, 4, '{8'h20, 8'h30, 8'h40, 8'h10, 8'h00, 8'h00}, 1'b0, 1'b1, 4, 8'h10, 4};
      vecs[4] = '{8'h01, 6, '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h03}, 1'b0, 1'b1, 4, 8'h03, 6};

      model_reset();
      #12;
      chk("reset.busy",   32'(busy),        0);
      chk("reset.done",   32'(done),        0);
      chk("reset.period", 32'(period),      0);
      chk("reset.entry",  32'(entry_state), 0);
      chk("reset.steps",  32'(steps),       0);
      rst = 1'b0;
      #2;

      // x_valid while idle is ignored
      applyStimulus(0, 8'h00, 1, 8'h55, "idle_x");
      applyStimulus(0, 8'h00, 1, 8'h00, "idle_x2");

      for (int v = 0; v < 5; v++) begin
         applyStimulus(1, vecs[v].init, 0, 8'h00, "vec_start");
         chk("vec.busy_after_start", 32'(busy), 1);
         for (int j = 0; j < vecs[v].nx; j++) begin
            if (v % 2 == 1) applyStimulus(0, 8'h00, 0, 8'hEE, "vec_gap");
            applyStimulus(0, 8'h00, 1, vecs[v].xs[j], "vec_x");
         end
         chk("vec.done",     32'(done),        1);
         chk("vec.fixed_pt", 32'(fixed_pt),    32'(vecs[v].exp_fixed));
         chk("vec.cycle",    32'(cycle),       32'(vecs[v].exp_cycle));
         chk("vec.timeout",  32'(timeout),     0);
         chk("vec.period",   32'(period),      32'(vecs[v].exp_period));
         chk("vec.entry",    32'(entry_state), 32'(vecs[v].exp_entry));
         chk("vec.steps",    32'(steps),       32'(vecs[v].exp_steps));
         applyStimulus(0, 8'h00, 1, 8'h99, "vec_hold");
      end

      // period 5 exceeds DEPTH and must time out at exactly MAX_STEPS
      applyStimulus(1, 8'h01, 0, 8'h00, "p5_start");
      for (int j = 0; j < 25; j++) begin
         applyStimulus(0, 8'h00, 1, 8'((j % 5) + 2 == 6 ? 1 : (j % 5) + 2), "p5_x");
      end
      chk("p5.timeout", 32'(timeout), 1);
      chk("p5.cycle",   32'(cycle),   0);
      chk("p5.done",    32'(done),    1);
      chk("p5.period",  32'(period),  0);
      chk("p5.steps",   32'(steps),   20);

      // restart mid-track with a colliding x in the same cycle
      applyStimulus(1, 8'h33, 0, 8'h00, "rs_start");
      applyStimulus(0, 8'h00, 1, 8'h44, "rs_x");
      applyStimulus(1, 8'h07, 1, 8'h07, "rs_restart");
      chk("rs.steps_after_restart", 32'(steps), 0);
      chk("rs.done_after_restart",  32'(done),  0);
      applyStimulus(0, 8'h00, 1, 8'h07, "rs_x2");
      chk("rs.fixed_pt", 32'(fixed_pt), 1);
      chk("rs.steps",    32'(steps),    1);

      // reset mid-track abandons the trajectory
      applyStimulus(1, 8'h21, 0, 8'h00, "mr_start");
      applyStimulus(0, 8'h00, 1, 8'h22, "mr_x");
      applyStimulus(0, 8'h00, 1, 8'h23, "mr_x2");
      pulse_reset("mr_rst");
      applyStimulus(0, 8'h00, 1, 8'h21, "mr_ignored");
      chk("mr.busy",  32'(busy),  0);
      chk("mr.steps", 32'(steps), 0);
      applyStimulus(1, 8'h21, 0, 8'h00, "mr_restart");
      applyStimulus(0, 8'h00, 1, 8'h21, "mr_fixed");
      chk("mr.fixed_pt", 32'(fixed_pt), 1);

      // randomized trajectories over a small alphabet
      for (int t = 0; t < 40; t++) begin
         applyStimulus(1, 8'($urandom_range(0, 5)), 0, 8'h00, "rnd_start");
         for (int c = 0; c < 30; c++) begin
            if ($urandom_range(0, 60) == 0)
               applyStimulus(1, 8'($urandom_range(0, 5)), $urandom_range(0, 1), 8'($urandom_range(0, 5)), "rnd_mid_start");
            else
               applyStimulus(0, 8'h00, ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 5 + t % 4)), "rnd_x");
         end
         if (t % 13 == 12) pulse_reset("rnd_rst");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
